id_issue_stage: RTL
===================

# id_issue_stage

Decode/issue stage of the 16-bit pipelined core, sitting between fetch and execute and directly upstream of the register file's read ports. It buffers one fetched instruction, decodes its source and destination fields, and drives `p0_addr`/`p1_addr`/`re0`/`re1` into the register file. A 16-entry scoreboard stalls on read-after-write hazards against in-flight writers, and a registered ID/EX output is handed to execute over a valid/ready handshake. It also counts stall cycles and detects HLT.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating stall counter.
- `clk` in 1: core clock; the register file reads on clk low and writes on clk high.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: the fetch slot holds an instruction.
- `in_instr` in 16: instruction fields `[15:12]` op, `[11:8]` rd, `[7:4]` rs, `[3:0]` rt.
- `in_ready` out 1: the decode slot can accept an instruction this cycle.
- `flush` in 1: squash the decode slot and the ID/EX register (taken branch or jump).
- `wb_we` in 1, `wb_addr` in 4: writeback is occurring this cycle; the same signals go to the register file's `we`/`dst_addr`.
- `rf_p0_addr`, `rf_p1_addr` out 4: register file read addresses.
- `rf_re0`, `rf_re1` out 1: register file read enables.
- `rf_p0`, `rf_p1` in 16: register file read data, valid after clk low.
- `ex_valid` out 1 / `ex_ready` in 1: ID/EX handshake.
- `ex_op` out 4, `ex_dst` out 4, `ex_we` out 1, `ex_a` out 16, `ex_b` out 16, `ex_imm` out 8: registered decode results for execute.
- `halted` out 1: high once HLT has issued.
- `stall_cnt` out `STALL_CNT_W`: number of hazard-stall cycles.

## Operation
- Decode, by op:
  - 0x0–0x7 (ALU): srcs rs→p0, rt→p1; writes rd.
  - 0x8 LW: src rs; writes rd.
  - 0x9 SW: srcs rs→p0, rd→p1; no write.
  - 0xA LLB: no src; writes rd.
  - 0xB LHB: src rd→p0; writes rd.
  - 0xC B: no regs.
  - 0xD JAL: writes R15.
  - 0xE JR: src rs→p0.
  - 0xF HLT: no regs.
- `rf_re0`/`rf_re1` are high only when the decode slot is valid and the corresponding source is used. Unused addresses are driven to 0.
- `ex_imm` = `in_instr[7:0]` of the issued instruction. `ex_a`/`ex_b` are 0 for unused sources.
- Scoreboard: 16 pending bits. Bit 0 is never set.
- Hazard: the decode slot is valid and any used source has its pending bit set. A source of R0 is never a hazard.
- Issue condition: slot valid, no hazard, not halted, and (`!ex_valid` or `ex_ready`). On issue:
  - ID/EX loads the decoded fields and `rf_p0`/`rf_p1`.
  - The pending bit of the destination is set if `ex_we` and dst≠0.
- Writeback: on `wb_we`, `pending[wb_addr]` clears at the clock edge. If the same register is set by an issue in the same cycle, set wins.
- `in_ready` = !halted and (slot empty or issuing this cycle). This is single-entry buffering with full throughput.
- FSM states:
  - EMPTY: slot invalid. On an accepted instruction → FULL.
  - FULL: on issue without a new accept → EMPTY; on issue with accept, stay; on hazard or back-pressure, stay.
  - HALTED: entered when HLT issues. Absorbing until `rst`; `in_ready`=0 and no further issue.
- `flush`:
  - Invalidates the slot and `ex_valid` at the edge and forces EMPTY.
  - Scoreboard bits already set remain, because those instructions are in flight downstream.
  - Flush has priority over accept and issue in the same cycle.
  - Flush in HALTED has no effect.
- `stall_cnt` increments in each FULL cycle with a hazard. It saturates at all-ones.

## Timing
- Reset values:
  - FSM = EMPTY, scoreboard = 0, `ex_valid`=0, `ex_op`/`ex_dst`/`ex_imm`/`ex_a`/`ex_b`=0, `ex_we`=0, `halted`=0, `stall_cnt`=0.
  - `in_ready`=1 after reset deasserts.
- Latency: an instruction accepted at edge N is presented on `rf_*` addresses during cycle N+1. With no hazard it appears on `ex_*` after edge N+1, so decode latency is 1 cycle.
- Register file reads settle in the clk-low half of the cycle. Operands are captured at the following rising edge.
- Writeback of register r at cycle W clears its pending bit at edge W. A dependent instruction issues in cycle W+1, when the register file has written in the high phase and reads in the low phase, so it gets the new value. No bypass is needed.
- `ex_*` holds stable while `ex_valid && !ex_ready`.
- `halted` rises at the same edge at which HLT loads into ID/EX.

## Test plan
- Independent stream `ADD R1,R2,R3`; `ADD R4,R5,R6` with `ex_ready`=1 → one issue per cycle. `ex_a`/`ex_b` equal the register file contents of R2/R3 and R5/R6. `stall_cnt`=0.
- `ADD R1,R2,R3` then `SUB R4,R1,R5`, with writeback of R1 three cycles later → SUB stalls 3 cycles. Its `ex_a` equals the written-back R1 value. `stall_cnt`=3.
- `LLB R0,0x55` then `ADD R2,R0,R0` → no stall. R0 is never pending.
- Hold `ex_ready`=0 for 4 cycles with the slot full → `in_ready`=0 and `ex_*` held unchanged. Release → issue resumes with no lost instruction.
- Flush while a hazard-stalled instruction is in the slot → slot emptied and `ex_valid`=0 next cycle. The pending bit of the earlier writer stays set until its writeback.
- HLT issue → `halted`=1 and `in_ready`=0 thereafter, ignoring `in_valid`. Assert `rst` mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/id_issue_stage.sv
// Decode/issue stage: one-entry decode slot, 16-bit RAW scoreboard, registered ID/EX handshake.
// Latency: instruction accepted at edge N drives the register file in cycle N+1 and is on ex_* after edge N+1.
// Backpressure: in_ready drops while the slot is full and cannot issue (hazard, ex stall) and permanently after HLT.
module id_issue_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [15:0]            in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   wb_we,
  input  logic [3:0]             wb_addr,
  output logic [3:0]             rf_p0_addr,
  output logic [3:0]             rf_p1_addr,
  output logic                   rf_re0,
  output logic                   rf_re1,
  input  logic [15:0]            rf_p0,
  input  logic [15:0]            rf_p1,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [3:0]             ex_op,
  output logic [3:0]             ex_dst,
  output logic                   ex_we,
  output logic [15:0]            ex_a,
  output logic [15:0]            ex_b,
  output logic [7:0]             ex_imm,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // State
  state_t                 state_q, state_d;
  logic [15:0]            instr_q, instr_d;
  logic [15:0]            pend_q, pend_d;
  logic                   ex_valid_q;
  logic [3:0]             ex_op_q;
  logic [3:0]             ex_dst_q;
  logic                   ex_we_q;
  logic [15:0]            ex_a_q;
  logic [15:0]            ex_b_q;
  logic [7:0]             ex_imm_q;
  logic [STALL_CNT_W-1:0] stall_q;

  // Decoded fields of the instruction sitting in the slot
  logic [3:0] op, rd, rs, rt;
  logic       use0, use1, dst_we;
  logic [3:0] src0, src1, dst;

  logic slot_vld, hazard, issue_ok, issue, accept;

  assign op = instr_q[15:12];
  assign rd = instr_q[11:8];
  assign rs = instr_q[7:4];
  assign rt = instr_q[3:0];

  // Source/destination usage per opcode; unused fields stay 0 so they never hazard or leak into ex_*
  always_comb begin
    use0   = 1'b0;
    use1   = 1'b0;
    src0   = 4'd0;
    src1   = 4'd0;
    dst_we = 1'b0;
    dst    = 4'd0;
    case (op)
      OP_LW: begin
        use0   = 1'b1;
        src0   = rs;
        dst_we = 1'b1;
        dst    = rd;
      end
      OP_SW: begin
        use0 = 1'b1;
        src0 = rs;
        use1 = 1'b1;
        src1 = rd;
      end
      OP_LLB: begin
        dst_we = 1'b1;
        dst    = rd;
      end
      OP_LHB: begin
        use0   = 1'b1;
        src0   = rd;
        dst_we = 1'b1;
        dst    = rd;
      end
      OP_B: begin
      end
      OP_JAL: begin
        dst_we = 1'b1;
        dst    = 4'hF;
      end
      OP_JR: begin
        use0 = 1'b1;
        src0 = rs;
      end
      OP_HLT: begin
      end
      default: begin
        // 0x0-0x7 are the ALU ops
        use0   = 1'b1;
        src0   = rs;
        use1   = 1'b1;
        src1   = rt;
        dst_we = 1'b1;
        dst    = rd;
      end
    endcase
  end

  assign slot_vld = (state_q == ST_FULL);
  assign halted   = (state_q == ST_HALTED);

  // R0 is hardwired so it is never a hazard, even though pend_q[0] is also kept clear
  assign hazard = slot_vld &&
                  ((use0 && (src0 != 4'd0) && pend_q[src0]) ||
                   (use1 && (src1 != 4'd0) && pend_q[src1]));

  // issue_ok ignores flush so in_ready has no combinational path from flush;
  // the actual state updates use issue, which flush overrides.
  assign issue_ok = slot_vld && !hazard && (!ex_valid_q || ex_ready);
  assign issue    = issue_ok && !flush;

  // Register file read port drive: addresses parked at 0 whenever the port is not needed
  assign rf_re0     = slot_vld && use0;
  assign rf_re1     = slot_vld && use1;
  assign rf_p0_addr = rf_re0 ? src0 : 4'd0;
  assign rf_p1_addr = rf_re1 ? src1 : 4'd0;

  // Slot FSM next state and accept handshake; flush beats accept and issue, HALTED absorbs everything.
  // An instruction accepted in the same cycle HLT issues is dropped, as nothing issues after HLT.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    in_ready = !halted && (!slot_vld || issue_ok);
    accept   = in_valid && in_ready && !flush;
    if (accept) begin
      instr_d = in_instr;
    end
    case (state_q)
      ST_EMPTY: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (issue) begin
          if (op == OP_HLT) begin
            state_d = ST_HALTED;
          end else if (accept) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Scoreboard: writeback clears, issue sets, set wins on the same register; flush leaves in-flight bits alone
  always_comb begin
    pend_d = pend_q;
    if (wb_we) begin
      pend_d[wb_addr] = 1'b0;
    end
    if (issue && dst_we && (dst != 4'd0)) begin
      pend_d[dst] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Slot, FSM and scoreboard registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      instr_q <= 16'd0;
      pend_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
    end
  end

  // ID/EX register: loads on issue, otherwise holds its payload; valid drops on consume or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= 4'd0;
      ex_dst_q   <= 4'd0;
      ex_we_q    <= 1'b0;
      ex_a_q     <= 16'd0;
      ex_b_q     <= 16'd0;
      ex_imm_q   <= 8'd0;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      ex_op_q    <= op;
      ex_dst_q   <= dst;
      ex_we_q    <= dst_we;
      ex_a_q     <= use0 ? rf_p0 : 16'd0;
      ex_b_q     <= use1 ? rf_p1 : 16'd0;
      ex_imm_q   <= instr_q[7:0];
    end else if (flush && !halted) begin
      ex_valid_q <= 1'b0;
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  // Saturating count of cycles lost to RAW hazards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (hazard && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_op     = ex_op_q;
  assign ex_dst    = ex_dst_q;
  assign ex_we     = ex_we_q;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;
  assign ex_imm    = ex_imm_q;
  assign stall_cnt = stall_q;

endmodule
